// File: rtl/fir_pkg.sv
// Shared types and helpers for the transposed-form FIR filter.
//   fir_state_t      : coefficient-load controller states (RUN, LOAD)
//   fir_acc_w()      : accumulator width, wide enough that no tap sum can overflow
//   fir_round()      : round-half-up arithmetic right shift
//   fir_saturate()   : clamp to a signed output width
//   fir_out_of_range : detect values that would need clamping
// Helpers work on a fixed 128-bit signed carrier so they serve any
// accumulator/output width up to that size.
package fir_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } fir_state_t;

  localparam int unsigned FIR_WIDE_W = 128;
  typedef logic signed [FIR_WIDE_W-1:0] fir_wide_t;

  function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  function automatic fir_wide_t fir_round(input fir_wide_t v, input int unsigned shift);
    fir_wide_t half;
    if (shift == 0) return v;
    half = fir_wide_t'(1) <<< (shift - 1);
    return (v + half) >>> shift;
  endfunction

  function automatic fir_wide_t fir_max(input int unsigned w);
    return (fir_wide_t'(1) <<< (w - 1)) - fir_wide_t'(1);
  endfunction

  function automatic fir_wide_t fir_min(input int unsigned w);
    return -(fir_wide_t'(1) <<< (w - 1));
  endfunction

  function automatic logic fir_out_of_range(input fir_wide_t v, input int unsigned w);
    return (v > fir_max(w)) || (v < fir_min(w));
  endfunction

  function automatic fir_wide_t fir_saturate(input fir_wide_t v, input int unsigned w);
    if (v > fir_max(w)) return fir_max(w);
    if (v < fir_min(w)) return fir_min(w);
    return v;
  endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-form FIR tap: a coefficient register plus the partial-sum
// register that follows it in the adder chain.
//   coef_we/coef_data : load this tap's coefficient
//   clear             : zero the partial sum (priority over en)
//   en                : advance the partial sum, z_out <= h*x + z_in
//   x                 : broadcast sample
//   z_in / z_out      : partial sum from the next tap / held partial sum
module fir_tap
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned COEF_W = 32,
  parameter int unsigned ACC_W  = 71
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     coef_we,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [ACC_W-1:0]  z_in,
  output logic signed [ACC_W-1:0]  z_out
);

  logic signed [COEF_W-1:0]        h;
  logic signed [DATA_W+COEF_W-1:0] prod;

  assign prod = h * x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h     <= '0;
      z_out <= '0;
    end else begin
      if (coef_we) h <= coef_data;
      if (clear)   z_out <= '0;
      else if (en) z_out <= ACC_W'(prod) + z_in;
    end
  end

endmodule

// File: rtl/fir_filter_tf.sv
// Programmable transposed-form FIR filter.
//   coef_load/coef_valid/coef_data : serial coefficient reload, h[0] first
//   coef_busy                      : high while coefficients are loading
//   in_valid/in_ready/x_in         : sample input handshake
//   out_valid/y_out                : filtered output, valid two cycles after
//                                    the cycle a sample is accepted
// Optional feature macro FIR_OUT_SAT_EN: clamp the output instead of
// wrapping, and add a sat_flag output that marks clamped results.
module fir_filter_tf
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned COEF_W    = 32,
  parameter int unsigned NUM_TAPS  = 100,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     coef_load,
  input  logic                     coef_valid,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  y_out
`ifdef FIR_OUT_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int unsigned ACC_W = fir_acc_w(DATA_W, COEF_W, NUM_TAPS);
  localparam int unsigned CNT_W = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TAPS - 1);

  fir_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_beat;
  logic accept;

  // Load controller
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_beat = 1'b0;
    case (state_q)
      RUN: begin
        if (coef_load) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (coef_load) begin
          cnt_d = '0;
        end else if (coef_valid) begin
          load_beat = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == RUN) && !coef_load;
  assign coef_busy = (state_q == LOAD);
  assign accept    = in_valid && in_ready;

  // Stage 1: control state, h[0] and the accepted sample
  logic signed [COEF_W-1:0] h0;
  logic signed [DATA_W-1:0] x_s1;
  logic                     v_s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      h0      <= '0;
      x_s1    <= '0;
      v_s1    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_beat && (cnt_q == '0)) h0 <= coef_data;
      v_s1 <= accept;
      if (accept) x_s1 <= x_in;
    end
  end

  // Partial-sum chain: tap k holds h[k] and z[k-1]; z[NUM_TAPS-1] is the
  // constant-zero input of the last tap. Sums advance on the same edge that
  // registers the output, so the output always sees z[0] from before the
  // update. A coef_load clears the chain on that edge, after the in-flight
  // sample has already used the old z[0].
  logic signed [ACC_W-1:0] z [NUM_TAPS];

  assign z[NUM_TAPS-1] = '0;

  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tap
    fir_tap #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .ACC_W (ACC_W)
    ) u_tap (
      .clk      (clk),
      .reset_n  (reset_n),
      .coef_we  (load_beat && (cnt_q == CNT_W'(k))),
      .coef_data(coef_data),
      .clear    (coef_load),
      .en       (v_s1),
      .x        (x_s1),
      .z_in     (z[k]),
      .z_out    (z[k-1])
    );
  end

  // Stage 2: final tap, rounding, narrowing
  logic signed [DATA_W+COEF_W-1:0] prod0;
  logic signed [ACC_W-1:0]         acc;
  fir_wide_t                       acc_wide;
  fir_wide_t                       rounded;
  logic signed [OUT_W-1:0]         y_next;

  assign prod0    = h0 * x_s1;
  assign acc      = ACC_W'(prod0) + z[0];
  assign acc_wide = fir_wide_t'(acc);
  assign rounded  = fir_round(acc_wide, OUT_SHIFT);

`ifdef FIR_OUT_SAT_EN
  logic ovf;
  assign ovf    = fir_out_of_range(rounded, OUT_W);
  assign y_next = OUT_W'(fir_saturate(rounded, OUT_W));
`else
  assign y_next = OUT_W'(rounded);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      y_out     <= '0;
`ifdef FIR_OUT_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      out_valid <= v_s1;
      if (v_s1) y_out <= y_next;
`ifdef FIR_OUT_SAT_EN
      sat_flag  <= v_s1 && ovf;
`endif
    end
  end

endmodule

// File: tb/tb_fir_filter_tf.sv
// Directed bench for fir_filter_tf. Two 4-tap instances share clock and
// reset: dut_a (OUT_W=32, no rounding) and dut_b (OUT_W=16, OUT_SHIFT=1).
module tb_fir_filter_tf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic               a_load, a_cv, a_busy, a_iv, a_ir, a_ov;
  logic signed [15:0] a_cd, a_x;
  logic signed [31:0] a_y;
  logic               b_load, b_cv, b_busy, b_iv, b_ir, b_ov;
  logic signed [15:0] b_cd, b_x;
  logic signed [15:0] b_y;
`ifdef FIR_OUT_SAT_EN
  logic               a_sat, b_sat;
`endif

  int unsigned total  = 0;
  int unsigned passed = 0;

  fir_filter_tf #(
    .DATA_W(16), .COEF_W(16), .NUM_TAPS(4), .OUT_W(32), .OUT_SHIFT(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .coef_load(a_load), .coef_valid(a_cv), .coef_data(a_cd), .coef_busy(a_busy),
    .in_valid(a_iv), .in_ready(a_ir), .x_in(a_x),
    .out_valid(a_ov), .y_out(a_y)
`ifdef FIR_OUT_SAT_EN
    , .sat_flag(a_sat)
`endif
  );

  fir_filter_tf #(
    .DATA_W(16), .COEF_W(16), .NUM_TAPS(4), .OUT_W(16), .OUT_SHIFT(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .coef_load(b_load), .coef_valid(b_cv), .coef_data(b_cd), .coef_busy(b_busy),
    .in_valid(b_iv), .in_ready(b_ir), .x_in(b_x),
    .out_valid(b_ov), .y_out(b_y)
`ifdef FIR_OUT_SAT_EN
    , .sat_flag(b_sat)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive one cycle on dut_a, then check the output produced by the
  // sample driven one step earlier.
  task automatic stepa(input logic v, input int x, input logic eov, input int ey,
                       input string tag);
    @(negedge clk);
    a_iv = v;
    a_x  = 16'(x);
    @(posedge clk);
    #1;
    chk({tag, ".ov"}, a_ov, eov);
    if (eov) chk({tag, ".y"}, a_y, ey);
`ifdef FIR_OUT_SAT_EN
    chk({tag, ".sat"}, a_sat, 1'b0);
`endif
  endtask

  task automatic stepb(input logic v, input int x, input logic eov, input int ey,
                       input logic esat, input string tag);
    @(negedge clk);
    b_iv = v;
    b_x  = 16'(x);
    @(posedge clk);
    #1;
    chk({tag, ".ov"}, b_ov, eov);
    if (eov) chk({tag, ".y"}, b_y, ey);
`ifdef FIR_OUT_SAT_EN
    chk({tag, ".sat"}, b_sat, eov && esat);
`endif
  endtask

  task automatic loada(input int c0, input int c1, input int c2, input int c3);
    int cs [4];
    cs = '{c0, c1, c2, c3};
    @(negedge clk);
    a_load = 1'b1;
    a_iv   = 1'b0;
    @(negedge clk);
    a_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_cv = 1'b1;
      a_cd = 16'(cs[i]);
      @(negedge clk);
    end
    a_cv = 1'b0;
  endtask

  task automatic loadb(input int c0, input int c1, input int c2, input int c3);
    int cs [4];
    cs = '{c0, c1, c2, c3};
    @(negedge clk);
    b_load = 1'b1;
    b_iv   = 1'b0;
    @(negedge clk);
    b_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_cv = 1'b1;
      b_cd = 16'(cs[i]);
      @(negedge clk);
    end
    b_cv = 1'b0;
  endtask

  initial begin
    int gap_exp [4];
    int beats [4];
    gap_exp = '{1, 3, 6, 10};
    beats   = '{5, 0, 0, 0};

    reset_n = 1'b0;
    a_load = 0; a_cv = 0; a_cd = '0; a_iv = 0; a_x = '0;
    b_load = 0; b_cv = 0; b_cd = '0; b_iv = 0; b_x = '0;

    // Reset state
    @(negedge clk);
    chk("rst.a_ov", a_ov, 1'b0);
    chk("rst.a_y", a_y, 0);
    chk("rst.a_busy", a_busy, 1'b0);
    chk("rst.a_ready", a_ir, 1'b1);
    chk("rst.b_ov", b_ov, 1'b0);
    chk("rst.b_y", b_y, 0);
    reset_n = 1'b1;

    // Zero coefficients after reset give zero output
    stepa(1, 5, 0, 0, "zero0");
    stepa(0, 0, 1, 0, "zero1");

    // Impulse, coefs 1,2,3,4
    loada(1, 2, 3, 4);
    chk("load.busy_done", a_busy, 1'b0);
    stepa(1, 1, 0, 0, "imp0");
    stepa(1, 0, 1, 1, "imp1");
    stepa(1, 0, 1, 2, "imp2");
    stepa(1, 0, 1, 3, "imp3");
    stepa(1, 0, 1, 4, "imp4");
    stepa(0, 0, 1, 0, "imp5");
    stepa(0, 0, 0, 0, "imp6");

    // Back-to-back step, then drain with zeros
    stepa(1, 1, 0, 0,  "stp0");
    stepa(1, 1, 1, 1,  "stp1");
    stepa(1, 1, 1, 3,  "stp2");
    stepa(1, 1, 1, 6,  "stp3");
    stepa(1, 1, 1, 10, "stp4");
    stepa(1, 0, 1, 10, "stp5");
    stepa(1, 0, 1, 9,  "drn1");
    stepa(1, 0, 1, 7,  "drn2");
    stepa(1, 0, 1, 4,  "drn3");
    stepa(0, 0, 1, 0,  "drn4");

    // Step with 3-cycle gaps: same values, just spaced out
    for (int i = 0; i < 4; i++) begin
      stepa(1, 1, 0, 0, "gap.in");
      stepa(0, 0, 1, gap_exp[i], "gap.out");
      stepa(0, 0, 0, 0, "gap.idle1");
      stepa(0, 0, 0, 0, "gap.idle2");
    end

    // Reload: in-flight sample uses old sums (1*1 + 9 = 10); same-cycle
    // sample is refused; sums cleared; new coefs 5,0,0,0 then x=2 -> 10
    stepa(1, 1, 0, 0, "rl.pre");
    @(negedge clk);
    a_load = 1'b1;
    a_iv   = 1'b1;
    a_x    = 16'sd99;
    #1;
    chk("rl.ready_on_load", a_ir, 1'b0);
    @(posedge clk);
    #1;
    chk("rl.inflight_ov", a_ov, 1'b1);
    chk("rl.inflight_y", a_y, 10);
    chk("rl.busy", a_busy, 1'b1);
    @(negedge clk);
    a_load = 1'b0;
    #1;
    chk("rl.ready_in_load", a_ir, 1'b0);
    @(posedge clk);
    #1;
    chk("rl.refused_ov", a_ov, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_cv = 1'b1;
      a_cd = 16'(beats[i]);
      @(posedge clk);
      #1;
      chk("rl.beat_ov", a_ov, 1'b0);
    end
    a_cv = 1'b0;
    chk("rl.busy_done", a_busy, 1'b0);
    stepa(1, 2, 0, 0,  "rl.x2");
    stepa(0, 0, 1, 10, "rl.y");

    // Rounding on dut_b, coefs 1,0,0,0
    loadb(1, 0, 0, 0);
    stepb(1, 3,  0, 0,  0, "rnd.p3");
    stepb(1, -3, 1, 2,  0, "rnd.m3");
    stepb(1, 2,  1, -1, 0, "rnd.p2");
    stepb(0, 0,  1, 1,  0, "rnd.end");
    stepb(0, 0,  0, 0,  0, "rnd.idle");

    // Overflow on dut_b: sums k*32767^2, rounded by one bit, into 16 bits
    loadb(32767, 32767, 32767, 32767);
`ifdef FIR_OUT_SAT_EN
    stepb(1, 32767, 0, 0,     1, "ovf0");
    stepb(1, 32767, 1, 32767, 1, "ovf1");
    stepb(1, 32767, 1, 32767, 1, "ovf2");
    stepb(1, 32767, 1, 32767, 1, "ovf3");
    stepb(0, 0,     1, 32767, 1, "ovf4");
`else
    stepb(1, 32767, 0, 0,      1, "ovf0");
    stepb(1, 32767, 1, -32767, 1, "ovf1");
    stepb(1, 32767, 1, 1,      1, "ovf2");
    stepb(1, 32767, 1, -32766, 1, "ovf3");
    stepb(0, 0,     1, 2,      1, "ovf4");
`endif
    stepb(0, 0, 0, 0, 0, "ovf.idle");

    // Reset during a partial load (2 of 4 beats)
    @(negedge clk);
    a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    a_cv   = 1'b1;
    a_cd   = 16'sd9;
    @(negedge clk);
    a_cd   = 16'sd9;
    @(negedge clk);
    a_cv   = 1'b0;
    chk("prst.busy_before", a_busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("prst.busy", a_busy, 1'b0);
    chk("prst.ready", a_ir, 1'b1);
    chk("prst.ov", a_ov, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    stepa(1, 7, 0, 0, "prst.x7");
    stepa(0, 0, 1, 0, "prst.y");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
